// File: rtl/char_stream_tx.sv
// Programmable character-stream transmitter: buffers up to 2**AW characters and replays them
// for rep+1 passes with gap idle cycles between passes, one character per clock.
module char_stream_tx #(
  parameter int unsigned    DW        = 8,
  parameter int unsigned    AW        = 4,
  parameter int unsigned    RW        = 4,
  parameter logic [DW-1:0]  IDLE_CHAR = 8'h00
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          clear,
  input  logic          start,
  input  logic [RW-1:0] rep,
  input  logic [RW-1:0] gap,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   len,
  output logic          err
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW:0] LenOne = 1;
  localparam logic [AW:0] LenFull = (AW + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   len_q, len_d;
  logic          err_q, err_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [RW-1:0] pass_q, pass_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [RW-1:0] gap_q, gap_d;
  logic [RW-1:0] gcnt_q, gcnt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [DW-1:0] mem [Depth];
  logic          mem_we;
  logic          full;
  logic          last;
  logic [AW-1:0] ptr_inc;

  assign full    = (len_q == LenFull);
  // ptr_q always indexes the character currently on dout while in StSend
  assign last    = ({1'b0, ptr_q} == (len_q - LenOne));
  assign ptr_inc = ptr_q + AW'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    err_d   = err_q;
    ptr_d   = ptr_q;
    pass_d  = pass_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mem_we  = 1'b0;

    if (clear) begin
      state_d = StIdle;
      len_d   = '0;
      err_d   = 1'b0;
      ptr_d   = '0;
      pass_d  = '0;
      gcnt_d  = '0;
      dout_d  = IDLE_CHAR;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (wr_en) begin
            if (full) begin
              err_d = 1'b1;
            end else begin
              mem_we = 1'b1;
              len_d  = len_q + LenOne;
            end
          end
          if (start) begin
            if (wr_en || (len_q == '0)) begin
              err_d = 1'b1;
            end else begin
              rep_d   = rep;
              gap_d   = gap;
              pass_d  = '0;
              ptr_d   = '0;
              state_d = StSend;
              dout_d  = mem[0];
              valid_d = 1'b1;
              busy_d  = 1'b1;
            end
          end
        end
        StSend: begin
          if (wr_en || start) err_d = 1'b1;
          if (last) begin
            ptr_d = '0;
            if (pass_q == rep_q) begin
              state_d = StIdle;
              dout_d  = IDLE_CHAR;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              pass_d = pass_q + RW'(1);
              if (gap_q == '0) begin
                dout_d = mem[0];
              end else begin
                state_d = StGap;
                gcnt_d  = gap_q;
                dout_d  = IDLE_CHAR;
                valid_d = 1'b0;
              end
            end
          end else begin
            ptr_d  = ptr_inc;
            dout_d = mem[ptr_inc];
          end
        end
        StGap: begin
          if (wr_en || start) err_d = 1'b1;
          if (gcnt_q == RW'(1)) begin
            state_d = StSend;
            dout_d  = mem[0];
            valid_d = 1'b1;
          end else begin
            gcnt_d = gcnt_q - RW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      pass_q  <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      dout_q  <= IDLE_CHAR;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      pass_q  <= pass_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Buffer storage is deliberately left out of reset and clear
  always_ff @(posedge clk) begin
    if (mem_we) mem[len_q[AW-1:0]] <= wr_data;
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign len        = len_q;
  assign err        = err_q;

endmodule
